// File: rtl/vga_timing_pkg.sv
// Preset VGA timing sets and helpers shared by the raster timing generator.
package vga_timing_pkg;

    localparam int unsigned VGA640_H_ACTIVE  = 640;
    localparam int unsigned VGA640_H_FP      = 16;
    localparam int unsigned VGA640_H_SYNC    = 96;
    localparam int unsigned VGA640_H_BP      = 48;
    localparam int unsigned VGA640_V_ACTIVE  = 480;
    localparam int unsigned VGA640_V_FP      = 10;
    localparam int unsigned VGA640_V_SYNC    = 2;
    localparam int unsigned VGA640_V_BP      = 33;
    localparam bit          VGA640_HSYNC_POL = 1'b0;
    localparam bit          VGA640_VSYNC_POL = 1'b0;

    // 800x600@60, 40 MHz pixel clock, 1056x628 total
    localparam int unsigned SVGA800_H_ACTIVE  = 800;
    localparam int unsigned SVGA800_H_FP      = 40;
    localparam int unsigned SVGA800_H_SYNC    = 128;
    localparam int unsigned SVGA800_H_BP      = 88;
    localparam int unsigned SVGA800_V_ACTIVE  = 600;
    localparam int unsigned SVGA800_V_FP      = 1;
    localparam int unsigned SVGA800_V_SYNC    = 4;
    localparam int unsigned SVGA800_V_BP      = 23;
    localparam bit          SVGA800_HSYNC_POL = 1'b1;
    localparam bit          SVGA800_VSYNC_POL = 1'b1;

    localparam int unsigned DEF_CNT_W   = 10;
    localparam int unsigned DEF_FRAME_W = 8;

    function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus decodes of the position it will hold after this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned FP     = VGA640_H_FP,
    parameter int unsigned SYNC   = VGA640_H_SYNC,
    parameter int unsigned BP     = VGA640_H_BP,
    parameter bit          POL    = 1'b0,
    parameter int unsigned W      = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         nxt_active,
    output logic         nxt_sync
);

    localparam int unsigned TOTAL = total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_timing
        $error("vga_axis_counter: every timing parameter must be >= 1");
    end
    if (64'(TOTAL) > (64'd1 << W)) begin : g_bad_width
        $error("vga_axis_counter: W too narrow for the axis total");
    end

    logic [W-1:0] nxt;

    assign wrap = (cnt == LAST);

    // Next position; the top registers decodes of this so flags never lag the counter
    always_comb begin
        nxt = cnt;
        if (step) begin
            nxt = wrap ? '0 : cnt + W'(1);
        end
    end

    assign nxt_active = (nxt < ACT_END);
    assign nxt_sync   = ((nxt >= SYNC_LO) && (nxt < SYNC_HI)) ? POL : ~POL;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with aligned, registered sync/blank/marker outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA640_H_ACTIVE,
    parameter int unsigned H_FP      = VGA640_H_FP,
    parameter int unsigned H_SYNC    = VGA640_H_SYNC,
    parameter int unsigned H_BP      = VGA640_H_BP,
    parameter int unsigned V_ACTIVE  = VGA640_V_ACTIVE,
    parameter int unsigned V_FP      = VGA640_V_FP,
    parameter int unsigned V_SYNC    = VGA640_V_SYNC,
    parameter int unsigned V_BP      = VGA640_V_BP,
    parameter bit          HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit          VSYNC_POL = VGA640_VSYNC_POL,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned FRAME_W   = DEF_FRAME_W
) (
    input  logic               clk25MHz,
    input  logic               reset,
    input  logic               ce,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               vblank,
    output logic               line_start,
    output logic               frame_start,
    output logic [CNT_W-1:0]   px,
    output logic [CNT_W-1:0]   py,
    output logic [FRAME_W-1:0] frame_cnt
);

    logic h_wrap, h_act, h_sync_lvl;
    logic v_wrap, v_act, v_sync_lvl;
    logic v_step;

    assign v_step = ce & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL),
        .W      (CNT_W)
    ) u_h (
        .clk        (clk25MHz),
        .reset      (reset),
        .step       (ce),
        .cnt        (px),
        .wrap       (h_wrap),
        .nxt_active (h_act),
        .nxt_sync   (h_sync_lvl)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL),
        .W      (CNT_W)
    ) u_v (
        .clk        (clk25MHz),
        .reset      (reset),
        .step       (v_step),
        .cnt        (py),
        .wrap       (v_wrap),
        .nxt_active (v_act),
        .nxt_sync   (v_sync_lvl)
    );

    // Flags describe the position the counters move to on this same edge
    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            video_on    <= 1'b1;
            vblank      <= 1'b0;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
            frame_cnt   <= '0;
        end else if (ce) begin
            hsync       <= h_sync_lvl;
            vsync       <= v_sync_lvl;
            video_on    <= h_act & v_act;
            vblank      <= ~v_act;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
            if (h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

endmodule
